// File: rtl/mac4_pkg.sv
// Shared definitions for the MAC4 datapath: multiplier and accumulator state
// encodings, the nibble width, and a width-to-nibble-count helper.
package mac4_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      SEND
   } mul_state_t;

   typedef enum logic [1:0] {
      ACC_IDLE,
      ACC_RUN,
      ACC_EMIT
   } acc_state_t;

   function automatic int nibbles(input int width);
      return width / NIBBLE_W;
   endfunction

endpackage

// File: rtl/nibble_serial_multiplier_nibble_shift_add.sv
// Combinational radix-16 step: adds A * nibble, shifted to nibble position
// cnt, into the 2*BIT_WIDTH product accumulator.
module nibble_shift_add
   import mac4_pkg::*;
#(
   parameter int BIT_WIDTH = 32,
   parameter int CNT_W     = 3
)
(
   input  logic [2*BIT_WIDTH-1:0] prod_i,
   input  logic [BIT_WIDTH-1:0]   opA_i,
   input  logic [NIBBLE_W-1:0]    nib_i,
   input  logic [CNT_W-1:0]       cnt_i,
   output logic [2*BIT_WIDTH-1:0] sum_o
);

   logic [2*BIT_WIDTH-1:0] partial;

   // A*nibble fits in BIT_WIDTH+4 bits, so even the top shift stays in range.
   always_comb begin
      partial = {{BIT_WIDTH{1'b0}}, opA_i} * {{(2*BIT_WIDTH-NIBBLE_W){1'b0}}, nib_i};
      sum_o   = prod_i + (partial << (NIBBLE_W * int'(cnt_i)));
   end

endmodule

// File: rtl/nibble_serial_multiplier.sv
// Nibble-serial unsigned multiplier feeding the MAC4 accumulator.
// Define MAC4_MUL_SATURATE_EN to clamp overflowing products to all-ones.
module nibble_serial_multiplier
   import mac4_pkg::*;
#(
   parameter int BIT_WIDTH = 32
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       last_in,
   input  logic [3:0] data_in,
   output logic [3:0] data_out,
   output logic       data_out_valid,
   output logic       acc_start,
   output logic       busy,
   output logic       ready
);

   localparam int N     = nibbles(BIT_WIDTH);
   localparam int CNT_W = $clog2(N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   mul_state_t             state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [BIT_WIDTH-1:0]   opA_q;
   logic [2*BIT_WIDTH-1:0] prod_q;
   logic [2*BIT_WIDTH-1:0] prodSum_d;
   logic                   session_q;
   logic                   last_q;
   logic [3:0]             dataOut_q;
   logic                   dataOutValid_q;
   logic                   accStart_q;
   logic                   ready_q;
   logic                   overflow;

   nibble_shift_add #(
      .BIT_WIDTH(BIT_WIDTH),
      .CNT_W    (CNT_W)
   ) u_shiftAdd (
      .prod_i(prod_q),
      .opA_i (opA_q),
      .nib_i (data_in),
      .cnt_i (cnt_q),
      .sum_o (prodSum_d)
   );

`ifdef MAC4_MUL_SATURATE_EN
   assign overflow = |prod_q[2*BIT_WIDTH-1:BIT_WIDTH];
`else
   assign overflow = 1'b0;
`endif

   // ready is registered and only rises one cycle after SEND ends, so the
   // accumulator always sees a quiet cycle between products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         opA_q          <= '0;
         prod_q         <= '0;
         session_q      <= 1'b0;
         last_q         <= 1'b0;
         dataOut_q      <= 4'h0;
         dataOutValid_q <= 1'b0;
         accStart_q     <= 1'b0;
         ready_q        <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               dataOut_q      <= 4'h0;
               dataOutValid_q <= 1'b0;
               accStart_q     <= 1'b0;
               ready_q        <= 1'b1;
               if (ready_q && start) begin
                  opA_q[3:0] <= data_in;
                  last_q     <= last_in;
                  cnt_q      <= CNT_W'(1);
                  ready_q    <= 1'b0;
                  state_q    <= LOAD_A;
               end
            end
            LOAD_A: begin
               opA_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W] <= data_in;
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  prod_q  <= '0;
                  state_q <= LOAD_B;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            LOAD_B: begin
               prod_q <= prodSum_d;
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= SEND;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            SEND: begin
               dataOut_q      <= overflow ? 4'hF : prod_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W];
               dataOutValid_q <= 1'b1;
               accStart_q     <= ((cnt_q == '0) && !session_q) || ((cnt_q == CNT_LAST) && last_q);
               if ((cnt_q == '0) && !session_q) begin
                  session_q <= 1'b1;
               end
               if (cnt_q == CNT_LAST) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  if (session_q && last_q) begin
                     session_q <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign data_out       = dataOut_q;
   assign data_out_valid = dataOutValid_q;
   assign acc_start      = accStart_q;
   assign ready          = ready_q;
   assign busy           = !ready_q;

endmodule

// File: tb/tb_nibble_serial_multiplier.sv
// Directed bench for nibble_serial_multiplier (BIT_WIDTH=32); expected
// products are hand-computed, MAC4_MUL_SATURATE_EN selects overflow results.
module tb_nibble_serial_multiplier;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       last_in;
   logic [3:0] data_in;
   logic [3:0] data_out;
   logic       data_out_valid;
   logic       acc_start;
   logic       busy;
   logic       ready;

   int checks;
   int failures;

   nibble_serial_multiplier #(.BIT_WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .last_in       (last_in),
      .data_in       (data_in),
      .data_out      (data_out),
      .data_out_valid(data_out_valid),
      .acc_start     (acc_start),
      .busy          (busy),
      .ready         (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives start with A nibble 0, then the rest of A and all of B; returns on
   // the falling edge after the last B nibble was sampled (cycle 16).
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic last, input bit pulseInB);
      @(negedge clk);
      start   = 1'b1;
      last_in = last;
      data_in = a[3:0];
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         start   = (pulseInB && (i == 10));
         last_in = 1'b0;
         data_in = (i < 8) ? a[4*i +: 4] : b[4*(i-8) +: 4];
      end
      @(negedge clk);
      start   = 1'b0;
      data_in = 4'h0;
   endtask

   task automatic collectProduct(input string name, input logic [31:0] expected, input logic [7:0] accMask, input bit pulseInSend);
      checkOutput({name, ".latency_valid"}, 32'(data_out_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput($sformatf("%s.valid%0d", name, i), 32'(data_out_valid), 32'd1);
         checkOutput($sformatf("%s.nib%0d", name, i), 32'(data_out), 32'(expected[4*i +: 4]));
         checkOutput($sformatf("%s.acc%0d", name, i), 32'(acc_start), 32'(accMask[i]));
         checkOutput($sformatf("%s.ready%0d", name, i), 32'(ready), 32'd0);
         start = (pulseInSend && (i == 3));
      end
      @(negedge clk);
      start = 1'b0;
      checkOutput({name, ".ready_back"}, 32'(ready), 32'd1);
      checkOutput({name, ".busy_back"}, 32'(busy), 32'd0);
      checkOutput({name, ".valid_drop"}, 32'(data_out_valid), 32'd0);
      checkOutput({name, ".data_zero"}, 32'(data_out), 32'd0);
   endtask

   initial begin
      logic [31:0] ovfExpected;
      logic [31:0] rstA;
      checks   = 0;
      failures = 0;
      start    = 1'b0;
      last_in  = 1'b0;
      data_in  = 4'h0;
      rst_n    = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset.ready", 32'(ready), 32'd1);
      checkOutput("reset.busy", 32'(busy), 32'd0);
      checkOutput("reset.valid", 32'(data_out_valid), 32'd0);
      checkOutput("reset.data", 32'(data_out), 32'd0);
      checkOutput("reset.acc", 32'(acc_start), 32'd0);
      rst_n = 1'b1;

      $display("[TB] 3*5 single-product session");
      applyStimulus(32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0);
      collectProduct("p3x5", 32'h0000_000F, 8'b1000_0001, 1'b0);

      $display("[TB] two-product session 7*6 then 2*2");
      applyStimulus(32'h0000_0007, 32'h0000_0006, 1'b0, 1'b0);
      collectProduct("p7x6", 32'h0000_002A, 8'b0000_0001, 1'b0);
      applyStimulus(32'h0000_0002, 32'h0000_0002, 1'b1, 1'b0);
      collectProduct("p2x2", 32'h0000_0004, 8'b1000_0000, 1'b0);

      $display("[TB] overflow FFFFFFFF*FFFFFFFF");
`ifdef MAC4_MUL_SATURATE_EN
      ovfExpected = 32'hFFFF_FFFF;
`else
      ovfExpected = 32'h0000_0001;
`endif
      applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
      collectProduct("povf", ovfExpected, 8'b1000_0001, 1'b0);

      $display("[TB] start pulsed during LOAD_B and SEND");
      applyStimulus(32'h0000_0005, 32'h0000_0009, 1'b1, 1'b1);
      collectProduct("p5x9", 32'h0000_002D, 8'b1000_0001, 1'b1);

      $display("[TB] reset during LOAD_B");
      rstA = 32'h1111_1111;
      @(negedge clk);
      start   = 1'b1;
      last_in = 1'b0;
      data_in = rstA[3:0];
      for (int i = 1; i < 11; i++) begin
         @(negedge clk);
         start   = 1'b0;
         data_in = rstA[4*(i%8) +: 4];
      end
      checkOutput("abort.busy_before", 32'(ready), 32'd0);
      rst_n = 1'b0;
      #1;
      checkOutput("abort.ready", 32'(ready), 32'd1);
      checkOutput("abort.busy", 32'(busy), 32'd0);
      checkOutput("abort.valid", 32'(data_out_valid), 32'd0);
      checkOutput("abort.data", 32'(data_out), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      data_in = 4'h0;
      applyStimulus(32'h0000_0002, 32'h0000_0003, 1'b1, 1'b0);
      collectProduct("p2x3", 32'h0000_0006, 8'b1000_0001, 1'b0);

      $display("[TB] zero operand B");
      applyStimulus(32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0);
      collectProduct("pzero", 32'h0000_0000, 8'b0000_0001, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
